// File: rtl/muldiv_pkg.sv
// ----------------------------------------------------------------------------
// muldiv_pkg: shared state encoding, opcode constants and width helper.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package muldiv_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_RUN  = 2'd2,
    S_FIX  = 2'd3
  } state_e;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_signfix.sv
// ----------------------------------------------------------------------------
// muldiv_signfix: conditional two's-complement negate of a W-bit value.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module muldiv_signfix #(
  parameter int W = 32
) (
  input  logic         neg_i,
  input  logic [W-1:0] val_i,
  output logic [W-1:0] val_o
);

  assign val_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ----------------------------------------------------------------------------
// muldiv_unit: iterative radix-2 multiply / restoring divide, one bit per clock.
// Rev 1.0 -- define MULDIV_SIGNED_EN to honour the sign input.
// ----------------------------------------------------------------------------
`default_nettype none

module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CW = clog2(WIDTH);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q;
  logic                 op_q, dz_q, done_q, div_zero_q;
  logic [WIDTH-1:0]     x_q, hi_q, lo_q;
  // Low half holds the raw/magnitude A before RUN; both ops iterate in place.
  logic [2*WIDTH-1:0]   p_q, p_next;

  logic [WIDTH-1:0]     mag_a, mag_b, quo_res, rem_res;
  logic [2*WIDTH-1:0]   prod_res;
  logic [WIDTH-1:0]     res_hi, res_lo;

  logic [WIDTH:0]       add_a, add_b, add_s;
  logic                 add_cin, add_co;

`ifdef MULDIV_SIGNED_EN
  logic sign_q, neg_res_q, neg_rem_q, sgn_a, sgn_b;

  assign sgn_a = sign_q & p_q[WIDTH-1];
  assign sgn_b = sign_q & x_q[WIDTH-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sign_q    <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      if (state_q == S_IDLE && start) sign_q <= sign;
      if (state_q == S_PREP) begin
        neg_res_q <= sgn_a ^ sgn_b;
        neg_rem_q <= sgn_a;
      end
    end
  end

  muldiv_signfix #(.W(WIDTH))   u_mag_a (.neg_i(sgn_a),     .val_i(p_q[WIDTH-1:0]),       .val_o(mag_a));
  muldiv_signfix #(.W(WIDTH))   u_mag_b (.neg_i(sgn_b),     .val_i(x_q),                  .val_o(mag_b));
  muldiv_signfix #(.W(2*WIDTH)) u_prod  (.neg_i(neg_res_q), .val_i(p_q),                  .val_o(prod_res));
  muldiv_signfix #(.W(WIDTH))   u_quo   (.neg_i(neg_res_q), .val_i(p_q[WIDTH-1:0]),       .val_o(quo_res));
  muldiv_signfix #(.W(WIDTH))   u_rem   (.neg_i(neg_rem_q), .val_i(p_q[2*WIDTH-1:WIDTH]), .val_o(rem_res));
`else
  logic unused_sign;
  assign unused_sign = sign;
  assign mag_a       = p_q[WIDTH-1:0];
  assign mag_b       = x_q;
  assign prod_res    = p_q;
  assign quo_res     = p_q[WIDTH-1:0];
  assign rem_res     = p_q[2*WIDTH-1:WIDTH];
`endif

  // Shared adder: accumulate for multiply, trial-subtract (carry = no borrow) for divide.
  always_comb begin
    add_a   = {1'b0, p_q[2*WIDTH-1:WIDTH]};
    add_b   = p_q[0] ? {1'b0, x_q} : '0;
    add_cin = 1'b0;
    if (op_q == OP_DIV) begin
      add_a   = p_q[2*WIDTH-1:WIDTH-1];
      add_b   = ~{1'b0, x_q};
      add_cin = 1'b1;
    end
    {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, add_cin};
  end

  always_comb begin
    p_next = {add_s, p_q[WIDTH-1:1]};
    if (op_q == OP_DIV) begin
      p_next = add_co ? {add_s[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1}
                      : {p_q[2*WIDTH-2:0], 1'b0};
    end
  end

  assign res_hi = (op_q == OP_DIV) ? rem_res : prod_res[2*WIDTH-1:WIDTH];
  assign res_lo = (op_q == OP_DIV) ? quo_res : prod_res[WIDTH-1:0];

  // A zero divisor still passes through FIX so its done pulse lands two edges after acceptance.
  always_comb begin
    state_d = state_q;
    busy    = (state_q != S_IDLE);
    case (state_q)
      S_IDLE:  if (start) state_d = S_PREP;
      S_PREP:  state_d = (op_q == OP_DIV && x_q == '0) ? S_FIX : S_RUN;
      S_RUN:   if (cnt_q == CW'(WIDTH-1)) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= OP_MULT;
      dz_q       <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      x_q        <= '0;
      p_q        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          op_q  <= op;
          p_q   <= {{WIDTH{1'b0}}, a};
          x_q   <= b;
          cnt_q <= '0;
        end
        S_PREP: begin
          p_q  <= {{WIDTH{1'b0}}, mag_a};
          x_q  <= mag_b;
          dz_q <= (op_q == OP_DIV) && (x_q == '0);
        end
        S_RUN: begin
          p_q   <= p_next;
          cnt_q <= cnt_q + CW'(1);
        end
        S_FIX: begin
          done_q     <= 1'b1;
          div_zero_q <= dz_q;
          if (!dz_q) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = div_zero_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_muldiv_unit: directed vector table plus handshake/reset corner sequences.
// Rev 1.0 -- expectations follow MULDIV_SIGNED_EN when it is defined.
// ----------------------------------------------------------------------------
`default_nettype none

module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;
`ifdef MULDIV_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, start, op, sign;
  logic [W-1:0] a, b, hi, lo;
  logic         busy, done, div_zero;

  int n_chk  = 0;
  int n_fail = 0;

  // hs/ls: expected with signed mode compiled in; hu/lu: with all ops unsigned.
  typedef struct {
    logic         op;
    logic         sg;
    logic [W-1:0] a, b, hs, ls, hu, lu;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .sign(sign),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic op_v, input logic sg_v, input logic [W-1:0] a_v, input logic [W-1:0] b_v);
    @(negedge clk);
    start = 1'b1; op = op_v; sign = sg_v; a = a_v; b = b_v;
    @(posedge clk);
    #1;
    start = 1'b0; op = ~op_v; sign = ~sg_v; a = ~a_v; b = ~b_v;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!done && lat < 200);
  endtask

  initial begin
    int lat, lat2, pulses;
    vec_t v;

    vecs[0]  = '{OP_MULT, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{OP_MULT, 1'b1, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 32'h00000006, 32'hFFFFFFEB};
    vecs[2]  = '{OP_DIV,  1'b0, 32'd100,      32'd7,        32'd2,        32'd14,       32'd2,        32'd14};
    vecs[3]  = '{OP_DIV,  1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h00000001, 32'h7FFFFFFC};
    vecs[4]  = '{OP_DIV,  1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 32'h80000000, 32'h00000000};
    vecs[5]  = '{OP_MULT, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 32'hFFFFFFFE, 32'h00000001};
    vecs[6]  = '{OP_DIV,  1'b1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 32'h00000007, 32'h00000000};
    vecs[7]  = '{OP_MULT, 1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 32'h00000001, 32'h00000000};
    vecs[8]  = '{OP_DIV,  1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF};
    vecs[9]  = '{OP_MULT, 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 32'h40000000, 32'h00000000};
    vecs[10] = '{OP_DIV,  1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, 32'hFFFFFF9C, 32'h00000000};
    vecs[11] = '{OP_DIV,  1'b0, 32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
    vecs[12] = '{OP_MULT, 1'b1, 32'h00000005, 32'h00000006, 32'h00000000, 32'h0000001E, 32'h00000000, 32'h0000001E};
    vecs[13] = '{OP_MULT, 1'b1, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 32'h80000000};
    vecs[14] = '{OP_MULT, 1'b0, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 32'h00000001, 32'h23456780};
    vecs[15] = '{OP_DIV,  1'b0, 32'd1000,     32'd3,        32'd1,        32'd333,      32'd1,        32'd333};

    reset = 1'b1; start = 1'b0; op = 1'b0; sign = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    chk("reset_dz", 64'(div_zero), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      issue(v.op, v.sg, v.a, v.b);
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'd1);
      wait_done(lat);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'd34);
      chk($sformatf("v%0d_hi", i), 64'(hi), 64'(SIGNED_BUILD ? v.hs : v.hu));
      chk($sformatf("v%0d_lo", i), 64'(lo), 64'(SIGNED_BUILD ? v.ls : v.lu));
      chk($sformatf("v%0d_dz", i), 64'(div_zero), 64'd0);
      chk($sformatf("v%0d_busy_done", i), 64'(busy), 64'd0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_pulse", i), 64'(done), 64'd0);
      chk($sformatf("v%0d_hi_hold", i), 64'(hi), 64'(SIGNED_BUILD ? v.hs : v.hu));
    end

    // Divide by zero: short latency, flag set, previous result retained.
    issue(OP_DIV, 1'b0, 32'd100, 32'd7);
    wait_done(lat);
    issue(OP_DIV, 1'b0, 32'd5, 32'd0);
    wait_done(lat);
    chk("dz_latency", 64'(lat), 64'd2);
    chk("dz_flag", 64'(div_zero), 64'd1);
    chk("dz_hi_kept", 64'(hi), 64'd2);
    chk("dz_lo_kept", 64'(lo), 64'd14);
    issue(OP_DIV, 1'b0, 32'd9, 32'd4);
    wait_done(lat);
    chk("dz_clear_flag", 64'(div_zero), 64'd0);
    chk("dz_clear_lo", 64'(lo), 64'd2);
    chk("dz_clear_hi", 64'(hi), 64'd1);

    // Start while busy is ignored; start in the done cycle is accepted.
    issue(OP_MULT, 1'b0, 32'd3, 32'd4);
    repeat (9) @(posedge clk);
    #1;
    start = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat2);
    chk("busy_ign_latency", 64'(10 + lat2), 64'd34);
    chk("busy_ign_lo", 64'(lo), 64'd12);
    chk("busy_ign_hi", 64'(hi), 64'd0);
    chk("busy_ign_dz", 64'(div_zero), 64'd0);
    start = 1'b1; op = OP_MULT; sign = 1'b0; a = 32'h00001234; b = 32'h00000010;
    @(posedge clk);
    #1;
    start = 1'b0; a = '0; b = '0;
    chk("done_start_busy", 64'(busy), 64'd1);
    wait_done(lat);
    chk("done_start_latency", 64'(lat), 64'd34);
    chk("done_start_lo", 64'(lo), 64'h12340);
    chk("done_start_hi", 64'(hi), 64'd0);

    // Asynchronous reset in the middle of a divide.
    issue(OP_DIV, 1'b0, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    chk("abort_no_done", 64'(pulses), 64'd0);
    issue(OP_DIV, 1'b0, 32'd1000, 32'd3);
    wait_done(lat);
    chk("after_abort_latency", 64'(lat), 64'd34);
    chk("after_abort_lo", 64'(lo), 64'd333);
    chk("after_abort_hi", 64'(hi), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
